// File: rtl/l1_cache_wt_if.sv
// Core word port and L2/pmem line port of the write-through L1 cache.
//   master : the environment side (core requests out, pmem responses out)
//   slave  : the cache side (core responses out, pmem requests out)
interface l1_cache_wt_if;
  // core side
  logic [15:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  // pmem side
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_wmask;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  mem_rdata, mem_resp,
    input  pmem_address, pmem_read, pmem_write, pmem_wmask, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output mem_rdata, mem_resp,
    output pmem_address, pmem_read, pmem_write, pmem_wmask, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/l1_cache_wt.sv
// Direct-mapped, write-through, no-write-allocate L1 cache, 16-byte lines.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset (clears valid bits and state)
//   bus     : l1_cache_wt_if.slave -- core word port and pmem line port
// Read hits answer in the request cycle; misses fill a whole line. Every write
// goes to pmem; the cached line is merged only when resident.
module l1_cache_wt #(
  parameter int unsigned NUM_LINES = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  l1_cache_wt_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = 12 - IDX_W;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t                 state;
  logic [NUM_LINES-1:0]   valid;
  logic [TAG_W-1:0]       tag_arr  [NUM_LINES];
  logic [127:0]           data_arr [NUM_LINES];

  logic [2:0]             word;
  logic [IDX_W-1:0]       index;
  logic [TAG_W-1:0]       tag;
  logic                   hit;
  logic [127:0]           line_merged;
  logic                   unused_addr_bit;

  // Address decode; bit 0 has no role in a word-wide port.
  assign word            = bus.mem_address[3:1];
  assign index           = bus.mem_address[4 +: IDX_W];
  assign tag             = bus.mem_address[15 -: TAG_W];
  assign unused_addr_bit = bus.mem_address[0];
  assign hit             = valid[index] && (tag_arr[index] == tag);

  // Controller state and valid bits; reset aborts any pmem transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      valid <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.mem_write)              state <= WRITE;
          else if (bus.mem_read && !hit)  state <= FILL;
        end
        FILL: begin
          if (bus.pmem_resp) begin
            valid[index] <= 1'b1;
            state        <= IDLE;
          end
        end
        WRITE: begin
          if (bus.pmem_resp) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Enabled bytes of the write merged into the resident line.
  always_comb begin
    line_merged = data_arr[index];
    for (int b = 0; b < 2; b++) begin
      if (bus.mem_byte_enable[b])
        line_merged[{word, 4'b0000} + 7'(8 * b) +: 8] = bus.mem_wdata[8 * b +: 8];
    end
  end

  // Tag/data arrays are not reset; valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (state == FILL && bus.pmem_resp) begin
      data_arr[index] <= bus.pmem_rdata;
      tag_arr[index]  <= tag;
    end else if (state == WRITE && bus.pmem_resp && hit) begin
      data_arr[index] <= line_merged;
    end
  end

  // Outputs decode straight from state so they collapse with reset.
  assign bus.pmem_read    = (state == FILL);
  assign bus.pmem_write   = (state == WRITE);
  assign bus.pmem_address = {bus.mem_address[15:4], 4'b0000};
  assign bus.pmem_wdata   = {8{bus.mem_wdata}};
  assign bus.pmem_wmask   = 16'(bus.mem_byte_enable) << {word, 1'b0};
  assign bus.mem_resp     = ((state == IDLE) && !bus.mem_write && bus.mem_read && hit)
                          || ((state == WRITE) && bus.pmem_resp);
  assign bus.mem_rdata    = data_arr[index][{word, 4'b0000} +: 16];

endmodule

// File: tb/tb_l1_cache_wt.sv
// Self-checking bench for l1_cache_wt: directed vector table, reset corner
// cases, then randomized traffic against a line-level reference model.
module tb_l1_cache_wt;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  l1_cache_wt_if bus();

  l1_cache_wt #(.NUM_LINES(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // pm: memory as the DUT writes it; ref_mem: memory as the stimulus implies.
  logic [127:0] pm      [4096];
  logic [127:0] ref_mem [4096];
  bit           mv [8];
  logic [8:0]   mt [8];

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    int          lat;
    bit          exp_fill;
    logic [15:0] exp_rdata;
    int          exp_cyc;
    logic [15:0] exp_mask;
  } vec_t;

  typedef struct {
    logic [15:0]  rdata;
    int           cyc;
    int           prd;
    int           pwr;
    logic [15:0]  paddr;
    logic [15:0]  pmask;
    logic [127:0] pwdata;
    bit           resp_at_presp;
    bit           timeout;
  } res_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one core request, play pmem with the given latency, collect results.
  task automatic run_req(input bit wr, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [1:0] be, input int lat, output res_t r);
    int pc;
    bit done;
    logic [127:0] ln;
    r.rdata = '0; r.cyc = 0; r.prd = 0; r.pwr = 0; r.paddr = '0; r.pmask = '0;
    r.pwdata = '0; r.resp_at_presp = 1'b0; r.timeout = 1'b0;
    bus.mem_address     = addr;
    bus.mem_wdata       = wdata;
    bus.mem_byte_enable = be;
    bus.mem_read        = !wr;
    bus.mem_write       = wr;
    pc   = 0;
    done = 1'b0;
    for (int c = 1; c <= 100 && !done; c++) begin
      @(negedge clk);
      if (bus.pmem_read || bus.pmem_write) begin
        pc++;
        if (bus.pmem_read) r.prd++; else r.pwr++;
        r.paddr  = bus.pmem_address;
        r.pmask  = bus.pmem_wmask;
        r.pwdata = bus.pmem_wdata;
        if (pc == lat) begin
          bus.pmem_resp = 1'b1;
          if (bus.pmem_read) begin
            bus.pmem_rdata = pm[bus.pmem_address[15:4]];
          end else begin
            ln = pm[bus.pmem_address[15:4]];
            for (int b = 0; b < 16; b++)
              if (bus.pmem_wmask[b]) ln[8 * b +: 8] = bus.pmem_wdata[8 * b +: 8];
            pm[bus.pmem_address[15:4]] = ln;
          end
        end
      end
      #1;
      if (bus.mem_resp) begin
        r.rdata         = bus.mem_rdata;
        r.cyc           = c;
        r.resp_at_presp = bus.pmem_resp;
        done            = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.pmem_resp = 1'b0;
      if (done) begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
      end
    end
    r.timeout = !done;
    if (!done) begin
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
    end
  endtask

  // Apply a vector, compare, and advance the reference model.
  task automatic apply(input vec_t v, input string nm);
    res_t r;
    logic [127:0] ln;
    int w;
    run_req(v.wr, v.addr, v.wdata, v.be, v.lat, r);
    check({nm, ".timeout"}, 128'(r.timeout), 128'(0));
    check({nm, ".cycles"}, 128'(r.cyc), 128'(v.exp_cyc));
    if (!v.wr) begin
      check({nm, ".rdata"}, 128'(r.rdata), 128'(v.exp_rdata));
      check({nm, ".fill_cycles"}, 128'(r.prd), 128'(v.exp_fill ? v.lat : 0));
      if (v.exp_fill) check({nm, ".paddr"}, 128'(r.paddr), 128'({v.addr[15:4], 4'h0}));
      mv[v.addr[6:4]] = 1'b1;
      mt[v.addr[6:4]] = v.addr[15:7];
    end else begin
      check({nm, ".wmask"}, 128'(r.pmask), 128'(v.exp_mask));
      check({nm, ".paddr"}, 128'(r.paddr), 128'({v.addr[15:4], 4'h0}));
      check({nm, ".wdata"}, r.pwdata, {8{v.wdata}});
      check({nm, ".resp_with_presp"}, 128'(r.resp_at_presp), 128'(1));
      check({nm, ".write_cycles"}, 128'(r.pwr), 128'(v.lat));
      ln = ref_mem[v.addr[15:4]];
      w  = int'(v.addr[3:1]);
      if (v.be[0]) ln[16 * w +: 8]     = v.wdata[7:0];
      if (v.be[1]) ln[16 * w + 8 +: 8] = v.wdata[15:8];
      ref_mem[v.addr[15:4]] = ln;
    end
  endtask

  // Build expectations from the model rules, then apply.
  task automatic model_req(input bit wr, input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [1:0] be, input int lat, input string nm);
    vec_t v;
    bit miss;
    logic [127:0] ln;
    miss        = !(mv[addr[6:4]] && mt[addr[6:4]] == addr[15:7]);
    ln          = ref_mem[addr[15:4]];
    v.wr        = wr;
    v.addr      = addr;
    v.wdata     = wdata;
    v.be        = be;
    v.lat       = lat;
    v.exp_fill  = !wr && miss;
    v.exp_rdata = ln[16 * int'(addr[3:1]) +: 16];
    v.exp_cyc   = wr ? lat + 1 : (miss ? lat + 2 : 1);
    v.exp_mask  = 16'(be) << (2 * int'(addr[3:1]));
    apply(v, nm);
  endtask

  vec_t tbl [12];
  logic [8:0] tags [4];

  initial begin
    logic [127:0] ln;
    logic [15:0]  a;

    tags[0] = 9'h024; tags[1] = 9'h0A5; tags[2] = 9'h1F3; tags[3] = 9'h100;
    for (int i = 0; i < 4096; i++) begin
      ln = {$urandom, $urandom, $urandom, $urandom};
      pm[i] = ln; ref_mem[i] = ln;
    end
    for (int w = 0; w < 8; w++) begin
      ln[16 * w +: 16] = 16'(w);
    end
    pm[12'h123] = ln; ref_mem[12'h123] = ln;
    pm[12'h567] = '0; ref_mem[12'h567] = '0;
    for (int w = 0; w < 8; w++) ln[16 * w +: 16] = 16'h9000 + 16'(w);
    pm[12'h923] = ln; ref_mem[12'h923] = ln;
    for (int i = 0; i < 8; i++) begin mv[i] = 1'b0; mt[i] = '0; end

    //          wr  addr      wdata     be     lat fill rdata     cyc mask
    tbl[0]  = '{0, 16'h1234, 16'h0000, 2'b00, 3, 1, 16'h0002, 5, 16'h0000};
    tbl[1]  = '{0, 16'h123E, 16'h0000, 2'b00, 3, 0, 16'h0007, 1, 16'h0000};
    tbl[2]  = '{1, 16'h1236, 16'hABCD, 2'b01, 2, 0, 16'h0000, 3, 16'h0040};
    tbl[3]  = '{0, 16'h1236, 16'h0000, 2'b00, 2, 0, 16'h00CD, 1, 16'h0000};
    tbl[4]  = '{1, 16'h5670, 16'h1111, 2'b11, 1, 0, 16'h0000, 2, 16'h0003};
    tbl[5]  = '{0, 16'h5670, 16'h0000, 2'b00, 2, 1, 16'h1111, 4, 16'h0000};
    tbl[6]  = '{0, 16'h1230, 16'h0000, 2'b00, 1, 0, 16'h0000, 1, 16'h0000};
    tbl[7]  = '{0, 16'h9230, 16'h0000, 2'b00, 2, 1, 16'h9000, 4, 16'h0000};
    tbl[8]  = '{0, 16'h1230, 16'h0000, 2'b00, 1, 1, 16'h0000, 3, 16'h0000};
    tbl[9]  = '{0, 16'h1232, 16'h0000, 2'b00, 1, 0, 16'h0001, 1, 16'h0000};
    tbl[10] = '{1, 16'h123E, 16'hBEEF, 2'b10, 1, 0, 16'h0000, 2, 16'h8000};
    tbl[11] = '{0, 16'h123E, 16'h0000, 2'b00, 1, 0, 16'hBE07, 1, 16'h0000};

    bus.mem_address = '0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    bus.mem_byte_enable = '0; bus.mem_wdata = '0;
    bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("reset.mem_resp",   128'(bus.mem_resp),   128'(0));
    check("reset.pmem_read",  128'(bus.pmem_read),  128'(0));
    check("reset.pmem_write", 128'(bus.pmem_write), 128'(0));
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    for (int i = 0; i < 12; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // Stray pmem_resp while idle must do nothing.
    @(negedge clk);
    bus.pmem_resp = 1'b1;
    bus.pmem_rdata = '1;
    #1;
    check("idle_presp.mem_resp",  128'(bus.mem_resp),  128'(0));
    check("idle_presp.pmem_read", 128'(bus.pmem_read), 128'(0));
    @(posedge clk);
    #1 bus.pmem_resp = 1'b0;

    // Reset in the middle of a fill: pmem_read drops at once, nothing valid.
    bus.mem_address = 16'h3450;
    bus.mem_read    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rstfill.pmem_read_before", 128'(bus.pmem_read), 128'(1));
    #2 reset_n = 1'b0;
    #1;
    check("rstfill.pmem_read_async", 128'(bus.pmem_read), 128'(0));
    check("rstfill.mem_resp",        128'(bus.mem_resp),  128'(0));
    @(posedge clk);
    #1;
    bus.mem_read = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) mv[i] = 1'b0;
    model_req(0, 16'h3450, 16'h0, 2'b00, 2, "rstfill.reread");
    model_req(0, 16'h1232, 16'h0, 2'b00, 2, "rstfill.old_line_gone");

    // Randomized traffic over a few tags per index for hits and evictions.
    for (int i = 0; i < 300; i++) begin
      a = {tags[$urandom_range(0, 3)], 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
      model_req($urandom_range(0, 2) == 0, a, 16'($urandom), 2'($urandom_range(0, 3)),
                $urandom_range(1, 4), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/l1_cache_wt.md
# l1_cache_wt

Direct-mapped, write-through, no-write-allocate L1 cache between the LC-3b core's word-wide memory port (mem_read/mem_write/mem_byte_enable/mem_resp) and the line-wide L2/physical memory port. Read hits complete in the request cycle. Read misses fill a full 128-bit line from pmem. Every write is forwarded to pmem, and the cached copy is updated only when the line is resident.

## Interface
- NUM_LINES, default 8 — number of cache lines. Must be a power of 2, from 2 to 256. Line size is fixed at 16 bytes (8 words).
- clk  in  1  — clock. All state changes on the rising edge.
- reset_n  in  1  — asynchronous, active-low reset.
- mem_address  in  16  — core byte address. Bit 0 is ignored for word selection.
- mem_read  in  1  — core read request, held until mem_resp.
- mem_write  in  1  — core write request, held until mem_resp.
- mem_byte_enable  in  2  — write byte lanes: bit 0 is the low byte, bit 1 is the high byte. Ignored on reads.
- mem_wdata  in  16  — core write data.
- mem_rdata  out  16  — read data. Valid only while mem_resp=1 for a read.
- mem_resp  out  1  — one-cycle completion pulse to the core.
- pmem_address  out  16  — line-aligned address; bits [3:0] are always 0.
- pmem_read  out  1  — line read request, held until pmem_resp.
- pmem_write  out  1  — masked line write request, held until pmem_resp.
- pmem_wmask  out  16  — byte mask for pmem_write.
- pmem_wdata  out  128  — write line.
- pmem_rdata  in  128  — fill line. Sampled only on pmem_resp in FILL.
- pmem_resp  in  1  — pmem completion, one cycle.

## Operation
- Address split:
  - word = mem_address[3:1]
  - index = mem_address[3+log2(NUM_LINES):4]
  - tag = remaining upper bits
- Storage: per line, a valid bit, a tag and 128 data bits, all in flops.
- hit = valid[index] and tag matches.
- FSM has three states: IDLE, FILL, WRITE.
- IDLE:
  - mem_write=1 → WRITE. mem_write has priority if mem_read is also set.
  - Else mem_read=1 and hit → mem_resp=1 combinationally, mem_rdata = word `word` of the line. Stay in IDLE.
  - Else mem_read=1 and miss → FILL.
  - No request → no outputs asserted.
- FILL:
  - Drive pmem_read=1 and pmem_address = {mem_address[15:4],4'b0}.
  - On pmem_resp: write pmem_rdata into the line, load the tag, set valid, → IDLE.
  - The held request then hits in IDLE on the next cycle.
- WRITE:
  - Drive pmem_write=1 and pmem_address line-aligned.
  - pmem_wdata = mem_wdata replicated into all 8 word lanes.
  - pmem_wmask bits {2*word+1, 2*word} = mem_byte_enable; all other mask bits are 0.
  - On pmem_resp: mem_resp=1 in the same cycle.
  - If hit, merge the enabled bytes into the cached word in the same edge. On a miss, no allocation.
  - → IDLE.
- Byte order within a line: word w occupies bits [16w+15:16w]; the low byte is the lower byte address.
- The request inputs (mem_address, mem_wdata, mem_byte_enable) must stay stable while the request is held. The block does not latch them.

## Timing
- Reset (reset_n=0, asynchronous):
  - All valid bits cleared, state = IDLE.
  - mem_resp, pmem_read and pmem_write = 0 immediately.
  - The data and tag arrays are not cleared.
- Read hit: mem_resp in the first cycle mem_read is seen (0 added cycles).
- Read miss: pmem_read is asserted from the cycle after the request until pmem_resp. The line is written on that edge, and mem_resp follows one cycle later.
  - Total latency = pmem latency + 2 cycles.
- Write: pmem_write is asserted from the cycle after the request. mem_resp equals pmem_resp in the same cycle.
  - Total latency = pmem latency + 1 cycle.
- mem_resp is never high for more than one cycle per request. A request dropped before mem_resp is undefined use.
- Reset asserted in FILL or WRITE: the transaction is aborted, pmem_read/pmem_write drop at once, and no line becomes valid.
- pmem_resp outside FILL or WRITE is ignored.
- An eviction (fill to a valid index with a different tag) overwrites the line silently. No writeback is needed because the cache is write-through.

## Test plan
- Cold read miss:
  - Stimulus: reset, then mem_read at 0x1234; pmem returns line 0x0007_0006_…_0001_0000 after 3 cycles.
  - Required: pmem_address=0x1230, pmem_read held 3 cycles, mem_resp one cycle later with mem_rdata=0x0002; total 5 cycles.
- Read hit after fill:
  - Stimulus: read 0x123E.
  - Required: mem_resp in the same cycle, mem_rdata=0x0007, no pmem activity.
- Write hit, low byte only:
  - Stimulus: write 0x1236, data 0xABCD, mem_byte_enable=01.
  - Required: pmem_wmask=0x0040; mem_resp coincides with pmem_resp; a following read of 0x1236 hits with 0x00CD.
- Write miss:
  - Stimulus: write 0x5670, data 0x1111, mem_byte_enable=11.
  - Required: pmem_wmask=0x0003, valid unchanged; a following read of 0x5670 misses and fills.
- Conflict eviction (NUM_LINES=8):
  - Stimulus: read 0x1230, then read 0x9230 (same index); pmem returns distinct lines.
  - Required: the second read misses and refills; a re-read of 0x1230 misses again.
- Reset during FILL:
  - Stimulus: assert reset_n=0 while pmem_read=1, release, then read the same address.
  - Required: pmem_read drops asynchronously, and the read after release is a miss with a full refill.
